// File: rtl/trial_divider_if.sv
// Request/response bundle for trial_divider: operands and start in, status and results out.
interface trial_divider_if #(
  parameter int N_WIDTH = 32,
  parameter int D_WIDTH = 16
);
  logic               start;
  logic [N_WIDTH-1:0] n;
  logic [D_WIDTH-1:0] d;
  logic               busy;
  logic               done;
  logic [N_WIDTH-1:0] q;
  logic [D_WIDTH-1:0] r;
  logic               is_factor;
  logic               div_by_zero;

  modport master (
    output start, n, d,
    input  busy, done, q, r, is_factor, div_by_zero
  );

  modport slave (
    input  start, n, d,
    output busy, done, q, r, is_factor, div_by_zero
  );
endinterface

// File: rtl/trial_divider.sv
// Sequential restoring divider, one quotient bit per clock, fixed latency.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | restoring steps (or a single pass-through cycle for d==0)
// DONE  | results valid, done pulse; start here is accepted back-to-back
module trial_divider #(
  parameter int N_WIDTH = 32,
  parameter int D_WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  trial_divider_if.slave  bus
);
  localparam int CW = $clog2(N_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [N_WIDTH-1:0] num;
  logic [D_WIDTH-1:0] dvs;
  logic [D_WIDTH-1:0] pr;
  logic [CW-1:0]      cnt;
  logic               dz;

  logic               busy_q, done_q, is_factor_q, div_by_zero_q;
  logic [N_WIDTH-1:0] q_q;
  logic [D_WIDTH-1:0] r_q;

  logic load, step, finish;

  logic [D_WIDTH:0]   trial, diff;
  logic               ge;
  logic [D_WIDTH-1:0] pr_step;
  logic [N_WIDTH-1:0] num_step;

  // num shifts the numerator out of its MSB while quotient bits enter at the LSB
  assign trial    = {pr, num[N_WIDTH-1]};
  assign ge       = trial >= {1'b0, dvs};
  assign diff     = trial - {1'b0, dvs};
  assign pr_step  = ge ? diff[D_WIDTH-1:0] : trial[D_WIDTH-1:0];
  assign num_step = {num[N_WIDTH-2:0], ge};

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        step = !dz;
        if (dz || cnt == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      num           <= '0;
      dvs           <= '0;
      pr            <= '0;
      cnt           <= '0;
      dz            <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      q_q           <= '0;
      r_q           <= '0;
      is_factor_q   <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next == RUN);
      done_q <= (state_next == DONE);
      if (load) begin
        num <= bus.n;
        dvs <= bus.d;
        pr  <= '0;
        cnt <= CW'(N_WIDTH - 1);
        dz  <= (bus.d == '0);
      end else if (step) begin
        num <= num_step;
        pr  <= pr_step;
        cnt <= cnt - CW'(1);
      end
      if (finish) begin
        if (dz) begin
          q_q           <= '1;
          r_q           <= num[D_WIDTH-1:0];
          is_factor_q   <= 1'b0;
          div_by_zero_q <= 1'b1;
        end else begin
          q_q           <= num_step;
          r_q           <= pr_step;
          is_factor_q   <= (pr_step == '0);
          div_by_zero_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.q           = q_q;
  assign bus.r           = r_q;
  assign bus.is_factor   = is_factor_q;
  assign bus.div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_trial_divider.sv
// Scoreboard bench for trial_divider: directed 32/16 vectors plus an exhaustive 8/4 sweep.
module tb_trial_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trial_divider_if #(.N_WIDTH(32), .D_WIDTH(16)) bus ();
  trial_divider_if #(.N_WIDTH(8),  .D_WIDTH(4))  bus2 ();

  trial_divider #(.N_WIDTH(32), .D_WIDTH(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  trial_divider #(.N_WIDTH(8), .D_WIDTH(4)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        f;
    logic        z;
    int          t;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a DUT raises done
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("q",           64'(bus.q),           64'(e.q));
        chk("r",           64'(bus.r),           64'(e.r));
        chk("is_factor",   64'(bus.is_factor),   64'(e.f));
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.z));
        chk("latency",     64'(cyc),             64'(e.t));
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.done === 1'b1) begin
      if (sb2.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL unexpected_done8: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb2.pop_front();
        chk("q8",           64'(bus2.q),           64'(e.q));
        chk("r8",           64'(bus2.r),           64'(e.r));
        chk("is_factor8",   64'(bus2.is_factor),   64'(e.f));
        chk("div_by_zero8", 64'(bus2.div_by_zero), 64'(e.z));
        chk("latency8",     64'(cyc),              64'(e.t));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge
  task automatic issue(input logic [31:0] nv, input logic [15:0] dv,
                       input logic [31:0] eq, input logic [15:0] er,
                       input logic ef, input logic ez, input bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.n     = nv;
    bus.d     = dv;
    if (push) begin
      e.q = eq; e.r = er; e.f = ef; e.z = ez;
      e.t = cyc + 1 + ((dv == 16'd0) ? 1 : 32);
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int b;
    b = budget;
    while (sb.size() != 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (sb.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy),        64'd0);
    chk({tag, "_done"}, 64'(bus.done),        64'd0);
    chk({tag, "_q"},    64'(bus.q),           64'd0);
    chk({tag, "_r"},    64'(bus.r),           64'd0);
    chk({tag, "_f"},    64'(bus.is_factor),   64'd0);
    chk({tag, "_z"},    64'(bus.div_by_zero), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int g;
    bus.start = 1'b0; bus.n = '0; bus.d = '0;
    bus2.start = 1'b0; bus2.n = '0; bus2.d = '0;

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    // 91/7 with busy-length measurement
    issue(32'd91, 16'd7, 32'd13, 16'd0, 1'b1, 1'b0, 1'b1);
    bc = 0;
    g = 0;
    while (bus.done !== 1'b1 && g < 100) begin
      if (bus.busy === 1'b1) bc++;
      @(negedge clk);
      g++;
    end
    chk("busy_len", 64'(bc), 64'd32);
    wait_empty(60);

    issue(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b0, 1'b1);
    wait_empty(60);
    issue(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b1, 1'b0, 1'b1);
    wait_empty(60);

    issue(32'd1234, 16'd0, 32'hFFFF_FFFF, 16'h04D2, 1'b0, 1'b1, 1'b1);
    wait_empty(10);
    issue(32'd10, 16'd3, 32'd3, 16'd1, 1'b0, 1'b0, 1'b1);
    wait_empty(60);

    // Abort: ignored start mid-run, then reset at cycle 20
    issue(32'd91, 16'd7, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("busy_mid", 64'(bus.busy), 64'd1);
    issue(32'd50, 16'd5, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("abort");
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd50, 16'd5, 32'd10, 16'd0, 1'b1, 1'b0, 1'b1);
    wait_empty(60);

    // Back-to-back with an ignored start at cycle 5 of the second run
    issue(32'd91, 16'd7, 32'd13, 16'd0, 1'b1, 1'b0, 1'b1);
    g = 0;
    while (bus.done !== 1'b1 && g < 60) begin
      @(negedge clk);
      g++;
    end
    issue(32'd35, 16'd5, 32'd7, 16'd0, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    issue(32'd999, 16'd2, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("hold_q", 64'(bus.q), 64'd13);
    chk("hold_f", 64'(bus.is_factor), 64'd1);
    wait_empty(60);
    repeat (40) @(negedge clk);

    // Exhaustive 8/4 sweep, each start issued in the previous done cycle
    for (int nv = 0; nv < 256; nv++) begin
      for (int dv = 0; dv < 16; dv++) begin
        exp_t e;
        bus2.start = 1'b1;
        bus2.n     = 8'(nv);
        bus2.d     = 4'(dv);
        if (dv == 0) begin
          e.q = 32'hFF; e.r = 16'(nv % 16); e.f = 1'b0; e.z = 1'b1;
          e.t = cyc + 2;
        end else begin
          e.q = 32'(nv / dv); e.r = 16'(nv % dv); e.f = ((nv % dv) == 0); e.z = 1'b0;
          e.t = cyc + 9;
        end
        sb2.push_back(e);
        @(negedge clk);
        bus2.start = 1'b0;
        g = 0;
        while (bus2.done !== 1'b1 && g < 20) begin
          @(negedge clk);
          g++;
        end
        if (bus2.done !== 1'b1) begin
          tests++;
          errors++;
          $display("FAIL timeout8: got no done expected done for n=%0d d=%0d", nv, dv);
          sb2.delete();
        end
      end
    end
    repeat (4) @(negedge clk);
    chk("sb2_drained", 64'(sb2.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
